// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared CPU constants (exception codes, NOP, instruction-memory bounds)
package cpu_defs_pkg;
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT = 32'h0000_6FFC;
endpackage

// File: rtl/fetch_exc_check.sv
// fetch_exc_check: flags misaligned or out-of-range fetch addresses as address-error-on-load
module fetch_exc_check
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] PC_BASE = IM_BASE,
  parameter logic [31:0] PC_LIMIT = IM_LIMIT
) (
  input  logic [31:0] pc,
  output logic [4:0]  exc,
  output logic [31:0] instr_mask
);
  logic bad;
  assign bad = (|pc[1:0]) || (pc < PC_BASE) || (pc > PC_LIMIT);
  assign exc = bad ? EXC_ADEL : EXC_NONE;
  // NOP_INSTR is all-zero, so masking the word to zero substitutes the NOP
  assign instr_mask = bad ? NOP_INSTR : '1;
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order {pc, instr} queue between fetch and decode; FETCH_EXC_EN adds fetch address checking
module fetch_buffer
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [31:0] PC_BASE = IM_BASE,
  parameter logic [31:0] PC_LIMIT = IM_LIMIT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [4:0]               out_exc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] instr_d;
  logic push, pop;
  assign in_ready = count != (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_pc = out_valid ? pc_q[rd_ptr] : '0;
  assign out_instr = out_valid ? instr_q[rd_ptr] : '0;
`ifdef FETCH_EXC_EN
  logic [4:0] exc_d;
  logic [31:0] instr_mask;
  logic [4:0] exc_q [DEPTH];
  fetch_exc_check #(.PC_BASE(PC_BASE), .PC_LIMIT(PC_LIMIT)) u_exc_check (
    .pc(in_pc),
    .exc(exc_d),
    .instr_mask(instr_mask)
  );
  assign instr_d = in_instr & instr_mask;
  assign out_exc = out_valid ? exc_q[rd_ptr] : EXC_NONE;
  always_ff @(posedge clk)
    if (!reset_n)
      for (int i = 0; i < DEPTH; i++) exc_q[i] <= EXC_NONE;
    else if (!flush && push)
      exc_q[wr_ptr] <= exc_d;
`else
  assign instr_d = in_instr;
  assign out_exc = EXC_NONE;
`endif
  // flush wins over a concurrent push/pop; storage is left stale since empty gates the outputs
  always_ff @(posedge clk)
    if (!reset_n) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        instr_q[i] <= '0;
      end
    end else if (flush) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr] <= in_pc;
        instr_q[wr_ptr] <= instr_d;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule
